pkt_gen_tx: RTL and testbench
=============================

// Module: pkt_gen_tx
// PURPOSE
//  AXI-Stream packet transmitter that drives the s_axis side of the packet queue.
//  Emits configurable-length packets with an incrementing byte pattern, tlast and tuser_mty.
//  Honours m_axis_tready backpressure.
//  On abort it cuts the current packet and pulses drop_incmpt_pkt so the queue discards the partial packet.
// PARAMETERS
//  C_DATA_WIDTH  64  tdata width in bits; multiple of 8; BYTES = C_DATA_WIDTH/8
//  C_MTY_WIDTH   3   tuser_mty width; must hold BYTES-1
//  C_LEN_BITS    16  packet length field width, in bytes
//  C_GAP_BITS    8   inter-packet idle-cycle field width
// PORTS
//  aclk              in   1             clock, all logic on rising edge
//  aresetn           in   1             reset, asynchronous, active-low
//  start             in   1             pulse; begins a run when idle
//  stop              in   1             pulse; graceful stop after the current packet
//  abort             in   1             pulse; immediate stop and drop of the partial packet
//  cfg_pkt_len       in   C_LEN_BITS    packet length in bytes, 1..2^C_LEN_BITS-1
//  cfg_pkt_num       in   32            packets per run; 0 = continuous
//  cfg_gap           in   C_GAP_BITS    idle cycles between packets
//  cfg_seed          in   8             first byte of packet 0
//  m_axis_tvalid     out  1             beat valid
//  m_axis_tdata      out  C_DATA_WIDTH  payload; byte 0 in bits [C_DATA_WIDTH-1 -: 8]
//  m_axis_tlast      out  1             last beat of packet
//  m_axis_tuser_mty  out  C_MTY_WIDTH   empty bytes in last beat; 0 on non-last beats
//  m_axis_tready     in   1             downstream ready
//  drop_incmpt_pkt   out  1             1-cycle pulse: partial packet aborted
//  busy              out  1             high outside IDLE
//  done              out  1             1-cycle pulse when a run ends (count reached, stop or abort)
//  cfg_err           out  1             1-cycle pulse: start rejected because cfg_pkt_len==0
//  pkt_sent_cnt      out  32            packets fully accepted this run
// BEHAVIOUR
//  Reset (async, aresetn=0): state IDLE; all outputs 0.
//   Mid-packet reset drops tvalid immediately; drop_incmpt_pkt is NOT pulsed.
//  States: IDLE, LOAD, SEND, GAP.
//  IDLE: start && cfg_pkt_len!=0 -> latch all cfg_*, clear pkt_sent_cnt, go to LOAD.
//   start && cfg_pkt_len==0 -> pulse cfg_err, stay in IDLE.
//   start is ignored in any other state. cfg_* changes are ignored after they are latched.
//  LOAD (1 cycle): compute per-run constants.
//   beats = ceil(len/BYTES).
//   last_mty = (BYTES - len%BYTES) % BYTES.
//  SEND: m_axis_tvalid=1.
//   A beat transfers on tvalid&&tready.
//   tdata, tlast and mty are held stable while tvalid&&!tready.
//  Latency: first beat valid 2 cycles after start (start -> LOAD -> SEND).
//  Payload: packet p, byte k = (seed + p + k) mod 256. Empty bytes in the last beat are the LSBs, driven 0.
//  Last-beat handshake:
//   pkt_sent_cnt increments.
//   Run complete (cfg_pkt_num!=0 and count reached) or stop seen -> IDLE, pulse done.
//   Else cfg_gap==0 -> next packet's first beat valid the next cycle (back-to-back, tvalid stays 1).
//   Else -> GAP with tvalid=0 for exactly cfg_gap cycles, then SEND.
//  stop: latched in any non-IDLE state. Takes effect at the next packet boundary (GAP exits straight to IDLE).
//  abort: in SEND with >=1 beat of the current packet already accepted:
//   tvalid=0 next cycle, drop_incmpt_pkt pulses 1 cycle, -> IDLE, pulse done.
//   Elsewhere (no beat accepted yet, or in LOAD/GAP): -> IDLE, pulse done, no drop pulse.
//   abort and stop together: abort wins.
//   abort in the same cycle as the last-beat handshake: the packet counts as complete; no drop pulse.
//  Counters wrap modulo their width. In continuous mode pkt_sent_cnt wraps 0xFFFFFFFF -> 0 with no side effect.
//  A length that is an exact multiple of BYTES gives mty=0 on the last beat. len < BYTES gives a single beat with tlast=1.
// TESTING
//  1. len=20, BYTES=8, num=2, gap=0, seed=0x10, tready=1 -> 6 contiguous beats.
//     tlast on beats 3 and 6, mty=4 on both; beat 1 = 0x1011..17; pkt_sent_cnt=2; done pulse.
//  2. len=16, num=1, tready low for 5 cycles on beat 2 -> beat 2 held stable.
//     2 beats total, mty=0 on the last beat.
//  3. len=24, gap=3, num=3 -> exactly 3 tvalid-low cycles between packets; busy=1 throughout the run.
//  4. num=0, abort after beat 2 of a 4-beat packet -> tvalid=0 next cycle, drop_incmpt_pkt=1 for one cycle, busy=0.
//  5. stop mid-packet, num=0 -> current packet completes with tlast, then IDLE, done=1.
//  6. cfg_pkt_len=0 with start -> cfg_err pulse, tvalid stays 0.
//     aresetn low mid-packet -> all outputs 0 immediately.

Source files
------------

// File: rtl/pkt_gen_tx.sv
// pkt_gen_tx -- AXI-Stream packet transmitter feeding the s_axis side of a packet queue.
//
// A run is started with a start pulse while idle. It emits cfg_pkt_len-byte packets
// (cfg_pkt_num of them, or forever when 0) with cfg_gap idle cycles between packets.
// Byte k of packet p carries (seed + p + k) mod 256, and byte 0 sits in the MSBs of
// tdata. The last beat of a packet carries tlast, and tuser_mty gives the number of
// empty LSB bytes, which are driven 0. The stop input ends the run at the next packet
// boundary. The abort input ends it at once; if the queue has already taken part of a
// packet, drop_incmpt_pkt tells the queue to discard that partial packet.
//
// Ports
//   aclk, aresetn          clock / asynchronous active-low reset
//   start, stop, abort     run control pulses
//   cfg_pkt_len/num/gap/seed  run configuration, latched on an accepted start
//   m_axis_*               AXI-Stream master (tvalid, tdata, tlast, tuser_mty, tready)
//   drop_incmpt_pkt        1-cycle pulse: partial packet cut by abort
//   busy                   high whenever not idle
//   done                   1-cycle pulse when a run ends
//   cfg_err                1-cycle pulse: start rejected, cfg_pkt_len == 0
//   pkt_sent_cnt           packets fully accepted in the current/last run
module pkt_gen_tx #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_MTY_WIDTH  = 3,
  parameter int C_LEN_BITS   = 16,
  parameter int C_GAP_BITS   = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    abort,
  input  logic [C_LEN_BITS-1:0]   cfg_pkt_len,
  input  logic [31:0]             cfg_pkt_num,
  input  logic [C_GAP_BITS-1:0]   cfg_gap,
  input  logic [7:0]              cfg_seed,
  output logic                    m_axis_tvalid,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [C_MTY_WIDTH-1:0]  m_axis_tuser_mty,
  input  logic                    m_axis_tready,
  output logic                    drop_incmpt_pkt,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [31:0]             pkt_sent_cnt
);

  localparam int BYTES = C_DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  state_t                  state;
  logic [C_LEN_BITS-1:0]   len_q;
  logic [31:0]             num_q;
  logic [C_GAP_BITS-1:0]   gap_q;
  logic [7:0]              seed_q;
  logic [C_LEN_BITS-1:0]   beats_q;    // beats per packet
  logic [C_MTY_WIDTH-1:0]  mty_q;      // empty bytes in the last beat
  logic [C_LEN_BITS-1:0]   beat_idx;   // index of the beat currently presented
  logic [7:0]              pkt_base;   // (seed + p) of the packet being sent
  logic [7:0]              beat_byte;  // value of byte 0 of the presented beat
  logic [C_GAP_BITS-1:0]   gap_cnt;
  logic                    stop_q;
  logic                    beat_acc;   // queue already holds part of this packet

  // Per-run constants derived from the latched length.
  logic [C_LEN_BITS:0]     len_round;
  logic [C_LEN_BITS-1:0]   beats_calc;
  logic [C_LEN_BITS-1:0]   len_rem;
  logic [C_MTY_WIDTH-1:0]  mty_calc;

  assign len_round  = {1'b0, len_q} + (C_LEN_BITS+1)'(BYTES - 1);
  assign beats_calc = C_LEN_BITS'(len_round / (C_LEN_BITS+1)'(BYTES));
  assign len_rem    = len_q % C_LEN_BITS'(BYTES);
  assign mty_calc   = (len_rem == '0) ? '0 : C_MTY_WIDTH'(C_LEN_BITS'(BYTES) - len_rem);

  // Build one beat: byte j = first + j, with the trailing 'empty' bytes zeroed.
  function automatic logic [C_DATA_WIDTH-1:0] make_beat(input logic [7:0]             first,
                                                        input logic [C_MTY_WIDTH-1:0] empty);
    logic [C_DATA_WIDTH-1:0] d;
    d = '0;
    for (int j = 0; j < BYTES; j++) begin
      if (j < BYTES - int'(empty)) d[C_DATA_WIDTH-1-8*j -: 8] = first + 8'(j);
    end
    return d;
  endfunction

  // Candidate next beats: first beat of a packet (from LOAD, or the packet after the
  // one finishing now) and the following beat of the current packet.
  logic [7:0]              first_byte;
  logic                    first_last;
  logic                    next_last;
  logic [C_MTY_WIDTH-1:0]  first_mty;
  logic [C_MTY_WIDTH-1:0]  next_mty;
  logic [C_DATA_WIDTH-1:0] first_data;
  logic [C_DATA_WIDTH-1:0] next_data;

  always_comb begin
    // NOTE: every variable gets a default before any condition so no latch is inferred.
    first_byte = pkt_base + 8'd1;
    first_last = (beats_q == C_LEN_BITS'(1));
    first_mty  = mty_q;
    if (state == S_LOAD) begin
      first_byte = seed_q;
      first_last = (beats_calc == C_LEN_BITS'(1));
      first_mty  = mty_calc;
    end
    if (!first_last) first_mty = '0;
    next_last = ((beat_idx + C_LEN_BITS'(2)) == beats_q);
    next_mty  = next_last ? mty_q : '0;
  end

  assign first_data = make_beat(first_byte, first_mty);
  assign next_data  = make_beat(beat_byte + 8'(BYTES), next_mty);

  logic hs, stop_now, run_complete, end_run, drop_now;

  assign hs           = m_axis_tvalid && m_axis_tready;
  assign stop_now     = stop_q || stop;
  assign run_complete = (num_q != 32'd0) && ((pkt_sent_cnt + 32'd1) == num_q);
  // Abort ends the run from any active state. Otherwise the run ends on a last-beat
  // handshake (count reached or stop pending), or in GAP once a stop is pending.
  assign end_run  = (abort && (state != S_IDLE))
                 || ((state == S_GAP) && stop_now)
                 || ((state == S_SEND) && hs && m_axis_tlast && (stop_now || run_complete));
  // A last beat taken together with abort completes its packet, so nothing is dropped.
  assign drop_now = (state == S_SEND) && abort && !(hs && m_axis_tlast) && (beat_acc || hs);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= S_IDLE;
      len_q            <= '0;
      num_q            <= '0;
      gap_q            <= '0;
      seed_q           <= '0;
      beats_q          <= '0;
      mty_q            <= '0;
      beat_idx         <= '0;
      pkt_base         <= '0;
      beat_byte        <= '0;
      gap_cnt          <= '0;
      stop_q           <= 1'b0;
      beat_acc         <= 1'b0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tdata     <= '0;
      m_axis_tlast     <= 1'b0;
      m_axis_tuser_mty <= '0;
      drop_incmpt_pkt  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_err          <= 1'b0;
      pkt_sent_cnt     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees the
      // pre-edge value regardless of statement order.
      done            <= 1'b0;
      cfg_err         <= 1'b0;
      drop_incmpt_pkt <= 1'b0;
      if (state != S_IDLE && stop) stop_q <= 1'b1;
      if (state == S_SEND && hs && m_axis_tlast) pkt_sent_cnt <= pkt_sent_cnt + 32'd1;

      if (end_run) begin
        state            <= S_IDLE;
        busy             <= 1'b0;
        done             <= 1'b1;
        drop_incmpt_pkt  <= drop_now;
        m_axis_tvalid    <= 1'b0;
        m_axis_tdata     <= '0;
        m_axis_tlast     <= 1'b0;
        m_axis_tuser_mty <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_pkt_len == '0) begin
                cfg_err <= 1'b1;
              end else begin
                len_q        <= cfg_pkt_len;
                num_q        <= cfg_pkt_num;
                gap_q        <= cfg_gap;
                seed_q       <= cfg_seed;
                pkt_sent_cnt <= '0;
                stop_q       <= 1'b0;
                busy         <= 1'b1;
                state        <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            beats_q          <= beats_calc;
            mty_q            <= mty_calc;
            pkt_base         <= seed_q;
            beat_byte        <= seed_q;
            beat_idx         <= '0;
            beat_acc         <= 1'b0;
            m_axis_tvalid    <= 1'b1;
            m_axis_tdata     <= first_data;
            m_axis_tlast     <= first_last;
            m_axis_tuser_mty <= first_mty;
            state            <= S_SEND;
          end
          S_SEND: begin
            if (hs) begin
              if (m_axis_tlast) begin
                // The next packet's first beat is staged now; during a gap it waits
                // behind tvalid=0.
                pkt_base         <= pkt_base + 8'd1;
                beat_byte        <= first_byte;
                beat_idx         <= '0;
                beat_acc         <= 1'b0;
                m_axis_tdata     <= first_data;
                m_axis_tlast     <= first_last;
                m_axis_tuser_mty <= first_mty;
                if (gap_q != '0) begin
                  m_axis_tvalid <= 1'b0;
                  gap_cnt       <= gap_q - C_GAP_BITS'(1);
                  state         <= S_GAP;
                end
              end else begin
                beat_idx         <= beat_idx + C_LEN_BITS'(1);
                beat_byte        <= beat_byte + 8'(BYTES);
                beat_acc         <= 1'b1;
                m_axis_tdata     <= next_data;
                m_axis_tlast     <= next_last;
                m_axis_tuser_mty <= next_mty;
              end
            end
          end
          S_GAP: begin
            if (gap_cnt == '0) begin
              m_axis_tvalid <= 1'b1;
              state         <= S_SEND;
            end else begin
              gap_cnt <= gap_cnt - C_GAP_BITS'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt_gen_tx.sv
// tb_pkt_gen_tx -- scoreboard bench for pkt_gen_tx.
// The stimulus pushes every beat a run should produce, computed from the byte-stream
// rule, into exp_q. A negedge monitor compares each presented beat with the head of
// the queue and pops it on a handshake. It also measures the idle gap between packets.
module tb_pkt_gen_tx;

  localparam int DW    = 64;
  localparam int MW    = 3;
  localparam int LB    = 16;
  localparam int GB    = 8;
  localparam int BYTES = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          abort = 1'b0;
  logic [LB-1:0] cfg_pkt_len = '0;
  logic [31:0]   cfg_pkt_num = '0;
  logic [GB-1:0] cfg_gap = '0;
  logic [7:0]    cfg_seed = '0;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [MW-1:0] m_axis_tuser_mty;
  logic          m_axis_tready = 1'b0;
  logic          drop_incmpt_pkt;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [31:0]   pkt_sent_cnt;

  pkt_gen_tx #(.C_DATA_WIDTH(DW), .C_MTY_WIDTH(MW), .C_LEN_BITS(LB), .C_GAP_BITS(GB)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .abort(abort),
    .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_num(cfg_pkt_num), .cfg_gap(cfg_gap),
    .cfg_seed(cfg_seed), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser_mty(m_axis_tuser_mty),
    .m_axis_tready(m_axis_tready), .drop_incmpt_pkt(drop_incmpt_pkt), .busy(busy),
    .done(done), .cfg_err(cfg_err), .pkt_sent_cnt(pkt_sent_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [MW-1:0] mty;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the packet as a byte stream, chopped into beats MSB-first.
  task automatic push_packet(input int seed, input int p, input int len);
    int    nb;
    int    k;
    beat_t e;
    nb = (len + BYTES - 1) / BYTES;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int j = 0; j < BYTES; j++) begin
        k = b * BYTES + j;
        if (k < len) e.data[DW-1-8*j -: 8] = 8'((seed + p + k) % 256);
      end
      e.last = (b == nb - 1);
      e.mty  = e.last ? MW'(nb * BYTES - len) : '0;
      exp_q.push_back(e);
    end
  endtask

  // tready: 0 = low, 1 = high, 2 = random with ready_pct percent high.
  int ready_mode = 0;
  int ready_pct  = 100;
  always @(posedge aclk) begin
    #2;
    if (ready_mode == 2) m_axis_tready = ($urandom_range(99) < ready_pct);
    else                 m_axis_tready = (ready_mode == 1);
  end

  // Monitor / scoreboard.
  int beats_seen = 0;
  bit last_was_tlast = 1'b0;
  bit gap_track = 1'b0;
  int gap_cnt = 0;
  int exp_gap = 0;
  bit prev_stall = 1'b0;
  bit prev_abort = 1'b0;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (prev_stall && !prev_abort) check("hold_tvalid", m_axis_tvalid, 1);
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tvalid", m_axis_tvalid, 0);
        end else begin
          check("tdata", m_axis_tdata, exp_q[0].data);
          check("tlast", m_axis_tlast, exp_q[0].last);
          check("tuser_mty", m_axis_tuser_mty, exp_q[0].mty);
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            beats_seen++;
            last_was_tlast = m_axis_tlast;
          end
        end
      end
      if (gap_track) begin
        if (m_axis_tvalid) begin
          check("gap_cycles", gap_cnt, exp_gap);
          gap_track = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        gap_track = 1'b1;
        gap_cnt   = 0;
      end
    end
    prev_stall = aresetn && m_axis_tvalid && !m_axis_tready;
    prev_abort = abort;
  end

  task automatic pulse_start();
    @(posedge aclk); #1 start = 1'b1;
    @(posedge aclk); #1 start = 1'b0;
  endtask

  task automatic start_run(input int len, input int num, input int gap, input int seed,
                           input int npush);
    cfg_pkt_len = LB'(len);
    cfg_pkt_num = 32'(num);
    cfg_gap     = GB'(gap);
    cfg_seed    = 8'(seed);
    exp_q.delete();
    exp_gap        = gap;
    gap_track      = 1'b0;
    beats_seen     = 0;
    last_was_tlast = 1'b0;
    for (int p = 0; p < npush; p++) push_packet(seed, p, len);
    pulse_start();
  endtask

  // Waits on negedges for done, checking busy on every cycle of the run.
  task automatic wait_done(input int budget, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge aclk);
      if (done) begin
        got = 1'b1;
        check({tag, "_busy_at_done"}, busy, 0);
      end else begin
        check({tag, "_busy_in_run"}, busy, 1);
      end
    end
    check({tag, "_done_seen"}, got, 1);
  endtask

  task automatic wait_tvalid(input int budget, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid) got = 1'b1;
    end
    check({tag, "_tvalid_seen"}, got, 1);
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (beats_seen < n && i < budget) begin
      @(posedge aclk);
      i++;
    end
    check({tag, "_beats_reached"}, beats_seen >= n, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_mty"}, m_axis_tuser_mty, 0);
    check({tag, "_drop"}, drop_incmpt_pkt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_pkt_cnt"}, pkt_sent_cnt, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, num, gap;

    // Reset state.
    repeat (3) @(posedge aclk);
    #1 check_all_zero("reset");
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    // Two 20-byte packets back to back, checking the two-cycle start latency.
    ready_mode = 1;
    start_run(20, 2, 0, 8'h10, 2);
    @(negedge aclk) check("t1_load_tvalid", m_axis_tvalid, 0);
    @(negedge aclk) check("t1_first_tvalid", m_axis_tvalid, 1);
    wait_done(100, "t1");
    check("t1_pkt_cnt", pkt_sent_cnt, 2);
    check("t1_beats", beats_seen, 6);
    check("t1_queue_left", exp_q.size(), 0);
    @(negedge aclk) check("t1_done_pulse_width", done, 0);

    // One 16-byte packet, with beat 2 held for five cycles of backpressure.
    ready_mode = 0;
    start_run(16, 1, 0, $urandom_range(255), 1);
    wait_tvalid(10, "t2");
    @(posedge aclk); #1 ready_mode = 1;
    @(posedge aclk); #1 ready_mode = 0;
    repeat (5) @(posedge aclk);
    #1 ready_mode = 1;
    wait_done(50, "t2");
    check("t2_pkt_cnt", pkt_sent_cnt, 1);
    check("t2_beats", beats_seen, 2);

    // Three 24-byte packets with a gap of 3.
    start_run(24, 3, 3, $urandom_range(255), 3);
    wait_done(200, "t3");
    check("t3_pkt_cnt", pkt_sent_cnt, 3);
    check("t3_queue_left", exp_q.size(), 0);

    // Continuous run, aborted after two beats of a four-beat packet.
    start_run(32, 0, 0, $urandom_range(255), 1);
    wait_beats(2, 50, "t4");
    #1 abort = 1'b1; ready_mode = 0;
    @(posedge aclk); #1 abort = 1'b0;
    @(negedge aclk);
    check("t4_tvalid", m_axis_tvalid, 0);
    check("t4_drop", drop_incmpt_pkt, 1);
    check("t4_busy", busy, 0);
    check("t4_done", done, 1);
    check("t4_pkt_cnt", pkt_sent_cnt, 0);
    @(negedge aclk) check("t4_drop_pulse_width", drop_incmpt_pkt, 0);

    // Abort before any beat has been accepted: no drop pulse.
    start_run($urandom_range(1, 40), 0, 0, $urandom_range(255), 1);
    repeat (3) @(posedge aclk);
    #1 abort = 1'b1;
    @(posedge aclk); #1 abort = 1'b0;
    @(negedge aclk);
    check("t4b_done", done, 1);
    check("t4b_drop", drop_incmpt_pkt, 0);
    check("t4b_tvalid", m_axis_tvalid, 0);

    // Abort together with the last-beat handshake: the packet counts, no drop pulse.
    start_run($urandom_range(1, BYTES), 0, 0, $urandom_range(255), 2);
    wait_tvalid(10, "t4c");
    @(posedge aclk); #1 abort = 1'b1; ready_mode = 1;
    @(posedge aclk); #1 abort = 1'b0; ready_mode = 0;
    @(negedge aclk);
    check("t4c_done", done, 1);
    check("t4c_drop", drop_incmpt_pkt, 0);
    check("t4c_pkt_cnt", pkt_sent_cnt, 1);

    // Stop mid-packet in a continuous run: the packet still completes.
    ready_mode = 2;
    ready_pct  = 70;
    start_run(40, 0, 1, $urandom_range(255), 2);
    wait_beats(2, 100, "t5");
    #1 stop = 1'b1;
    @(posedge aclk); #1 stop = 1'b0;
    wait_done(200, "t5");
    check("t5_pkt_cnt", pkt_sent_cnt, 1);
    check("t5_beats", beats_seen, 5);
    check("t5_ended_on_tlast", last_was_tlast, 1);

    // Random runs. start stays high and the cfg inputs are scrambled during the run.
    // A run latches its cfg values once, and start has no effect while a run is busy.
    for (int r = 0; r < 10; r++) begin
      len       = $urandom_range(1, 40);
      num       = $urandom_range(1, 3);
      gap       = $urandom_range(0, 3);
      ready_pct = $urandom_range(40, 100);
      start_run(len, num, gap, $urandom_range(255), num);
      start       = 1'b1;
      cfg_pkt_len = LB'($urandom_range(1, 100));
      cfg_pkt_num = 32'($urandom_range(1, 9));
      cfg_gap     = GB'($urandom_range(0, 9));
      cfg_seed    = 8'($urandom_range(255));
      wait_done(400, "rand");
      start = 1'b0;
      check("rand_pkt_cnt", pkt_sent_cnt, num);
      check("rand_queue_left", exp_q.size(), 0);
    end

    // Zero length rejected.
    ready_mode = 1;
    start_run(0, 1, 0, 0, 0);
    @(negedge aclk);
    check("t6_cfg_err", cfg_err, 1);
    check("t6_busy", busy, 0);
    check("t6_tvalid", m_axis_tvalid, 0);
    @(negedge aclk) check("t6_cfg_err_pulse_width", cfg_err, 0);
    repeat (3) @(negedge aclk);
    check("t6_tvalid_later", m_axis_tvalid, 0);

    // Reset in the middle of a packet clears every output immediately.
    start_run(48, 0, 0, $urandom_range(255), 1);
    repeat (4) @(posedge aclk);
    #2 aresetn = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge aclk) check("midreset_drop_later", drop_incmpt_pkt, 0);
    @(posedge aclk); #1 aresetn = 1'b1;
    exp_q.delete();
    gap_track = 1'b0;
    repeat (3) @(negedge aclk);
    check("postreset_tvalid", m_axis_tvalid, 0);
    check("postreset_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
